// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage encodings: MemOp codes (common with decode), access-unit FSM
// states and small lane helpers used when launching a data-memory request.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    MEMOP_NONE = 3'b000,
    MEMOP_BYTE = 3'b001,
    MEMOP_HALF = 3'b010,
    MEMOP_WORD = 3'b100
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == MEMOP_BYTE) || (op == MEMOP_HALF) || (op == MEMOP_WORD);
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEMOP_BYTE: return 4'b0001 << off;
      MEMOP_HALF: return off[1] ? 4'b1100 : 4'b0011;
      MEMOP_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lane_replicate(input logic [2:0] op, input logic [31:0] d);
    case (op)
      MEMOP_BYTE: return {4{d[7:0]}};
      MEMOP_HALF: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/half lane of a little-endian read word and
// sign- or zero-extends it to 32 bits; word loads pass straight through.
module load_aligner
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (op)
      MEMOP_BYTE: result = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      MEMOP_HALF: result = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller (req/ack port, byte enables, load extension).
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid,
  input  logic [2:0]  MemOp,
  input  logic        MemWrite,
  input  logic        MemUnsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Misaligned,
  output logic        BusError,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  mau_state_e  state, state_nx;
  logic [7:0]  cnt;
  logic [2:0]  op_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [1:0]  off_eff;
  logic        legal, accept, timeout_hit;
  logic [31:0] ld_ext;

  assign legal = op_legal(MemOp);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((MemOp == MEMOP_HALF) && Addr[0]) ||
                    ((MemOp == MEMOP_WORD) && (Addr[1:0] != 2'b00));
  assign accept   = Valid && legal && !misalign && !reset;
  assign off_eff  = Addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Misaligned <= 1'b0;
    else       Misaligned <= (state == ST_IDLE) && Valid && legal && misalign;
  end
`else
  assign accept = Valid && legal && !reset;
  // Misaligned halves/words are silently pulled down to their natural boundary.
  assign off_eff = (MemOp == MEMOP_HALF) ? {Addr[1], 1'b0} :
                   (MemOp == MEMOP_WORD) ? 2'b00 : Addr[1:0];
  assign Misaligned = 1'b0;
`endif

  assign timeout_hit = (state == ST_REQ) && !dm_ack && (cnt == 8'(WAIT_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_REQ;
      ST_REQ:  if (dm_ack || timeout_hit) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Low in DONE so the pipeline advances on the completion cycle.
  always_comb begin
    Stall = ((state == ST_IDLE) && accept) || (state == ST_REQ);
  end

  load_aligner u_load_aligner (
    .rdata       (dm_rdata),
    .offset      (off_q),
    .op          (op_q),
    .is_unsigned (uns_q),
    .result      (ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_be     <= 4'b0;
      dm_addr   <= 32'b0;
      dm_wdata  <= 32'b0;
      op_q      <= MEMOP_NONE;
      uns_q     <= 1'b0;
      off_q     <= 2'b0;
      cnt       <= 8'd0;
      LoadData  <= 32'b0;
      LoadValid <= 1'b0;
      BusError  <= 1'b0;
    end else begin
      LoadValid <= 1'b0;
      BusError  <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          dm_req   <= 1'b1;
          dm_we    <= MemWrite;
          dm_be    <= byte_enables(MemOp, off_eff);
          dm_addr  <= {Addr[31:2], 2'b00};
          dm_wdata <= lane_replicate(MemOp, StoreData);
          op_q     <= MemOp;
          uns_q    <= MemUnsigned;
          off_q    <= off_eff;
          cnt      <= 8'd0;
        end
        ST_REQ: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
              LoadData  <= ld_ext;
              LoadValid <= 1'b1;
            end
          end else if (timeout_hit) begin
            dm_req   <= 1'b0;
            BusError <= 1'b1;
            LoadData <= 32'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, timeout,
// misalignment (both build options) and reset abort.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk, reset, Valid, MemWrite, MemUnsigned, dm_ack;
  logic [2:0]  MemOp;
  logic [31:0] Addr, StoreData, dm_rdata;
  logic        Stall, LoadValid, Misaligned, BusError, dm_req, dm_we;
  logic [31:0] LoadData, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  int total = 0;
  int bad   = 0;

  // Per-access observations filled in by run_access.
  int          req_n, stall_n, lv_n, be_n, mis_n;
  logic [31:0] cap_be, cap_addr, cap_wdata, cap_we, ld_done;

  mem_access_unit #(.WAIT_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .MemOp(MemOp), .MemWrite(MemWrite),
    .MemUnsigned(MemUnsigned), .Addr(Addr), .StoreData(StoreData), .Stall(Stall),
    .LoadData(LoadData), .LoadValid(LoadValid), .Misaligned(Misaligned),
    .BusError(BusError), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pulses;
    lv_n  += int'(LoadValid);
    be_n  += int'(BusError);
    mis_n += int'(Misaligned);
  endtask

  // Starts #1 after an edge with the unit idle; ack_at is the 1-based REQ cycle
  // that sees dm_ack (0 = never). Ends #1 after the edge following DONE.
  task automatic run_access(input logic [2:0] op, input logic we, input logic uns,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int ack_at);
    req_n = 0; stall_n = 0; lv_n = 0; be_n = 0; mis_n = 0;
    cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = '0;
    Valid = 1'b1; MemOp = op; MemWrite = we; MemUnsigned = uns;
    Addr = addr; StoreData = sdata; dm_ack = 1'b0;
    #1 stall_n += int'(Stall);
    tick;
    Valid = 1'b0; MemOp = MEMOP_NONE; Addr = 32'hFFFF_FFFF; StoreData = 32'h5555_5555;
    sample_pulses();
    for (int c = 1; c <= 40; c++) begin
      if (!dm_req) break;
      req_n++;
      cap_be = 32'(dm_be); cap_addr = dm_addr; cap_wdata = dm_wdata; cap_we = 32'(dm_we);
      if (c == ack_at) begin
        dm_ack = 1'b1;
        dm_rdata = rdata;
      end
      #1 stall_n += int'(Stall);
      tick;
      dm_ack = 1'b0;
      dm_rdata = 32'hDEAD_0000;
      sample_pulses();
    end
    ld_done = LoadData;
    stall_n += int'(Stall);
    tick;
    sample_pulses();
  endtask

  initial begin
    reset = 1'b1; Valid = 1'b0; MemOp = MEMOP_NONE; MemWrite = 1'b0; MemUnsigned = 1'b0;
    Addr = '0; StoreData = '0; dm_ack = 1'b0; dm_rdata = '0;
    #12;
    check("rst_dm_req", 32'(dm_req), 0);
    check("rst_stall", 32'(Stall), 0);
    check("rst_loaddata", LoadData, 0);
    check("rst_pulses", 32'({LoadValid, BusError, Misaligned}), 0);
    check("rst_dm_be", 32'(dm_be), 0);
    @(negedge clk) reset = 1'b0;
    tick;

    // LB 0x103, sign-extended top lane, immediate ack
    run_access(MEMOP_BYTE, 1'b0, 1'b0, 32'h103, 32'h0, 32'h80AA_BBCC, 1);
    check("lb_be", cap_be, 32'b1000);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_we", cap_we, 0);
    check("lb_req_cycles", req_n, 1);
    check("lb_stall_cycles", stall_n, 2);
    check("lb_data", ld_done, 32'hFFFF_FF80);
    check("lb_loadvalid", lv_n, 1);

    // SH 0x202, ack on third REQ cycle
    run_access(MEMOP_HALF, 1'b1, 1'b0, 32'h202, 32'h1234_BEEF, 32'h0, 3);
    check("sh_be", cap_be, 32'b1100);
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sh_we", cap_we, 1);
    check("sh_stall_cycles", stall_n, 4);
    check("sh_no_loadvalid", lv_n, 0);
    check("sh_loaddata_held", ld_done, 32'hFFFF_FF80);

    run_access(MEMOP_HALF, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0000_F00D, 1);
    check("lhu_data", ld_done, 32'h0000_F00D);
    check("lhu_be", cap_be, 32'b0011);
    run_access(MEMOP_HALF, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8001_F00D, 1);
    check("lh_data", ld_done, 32'hFFFF_F00D);
    run_access(MEMOP_HALF, 1'b0, 1'b0, 32'h42, 32'h0, 32'h8001_F00D, 2);
    check("lh_hi_data", ld_done, 32'hFFFF_8001);
    run_access(MEMOP_BYTE, 1'b0, 1'b0, 32'h101, 32'h0, 32'h1122_3344, 1);
    check("lb_pos_data", ld_done, 32'h0000_0033);
    run_access(MEMOP_BYTE, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80AA_BBCC, 1);
    check("lbu_data", ld_done, 32'h0000_00AA);
    check("lbu_be", cap_be, 32'b0100);

    run_access(MEMOP_BYTE, 1'b1, 1'b0, 32'h31, 32'h1234_5678, 32'h0, 1);
    check("sb_be", cap_be, 32'b0010);
    check("sb_wdata", cap_wdata, 32'h7878_7878);
    run_access(MEMOP_WORD, 1'b1, 1'b0, 32'h30, 32'hDEAD_BEEF, 32'h0, 1);
    check("sw_be", cap_be, 32'b1111);
    check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);

    // Word load with MemUnsigned set still returns the raw word
    run_access(MEMOP_WORD, 1'b0, 1'b1, 32'h50, 32'h0, 32'h8765_4321, 1);
    check("lw_data", ld_done, 32'h8765_4321);

    // NOP and illegal codes: no request, no stall
    run_access(MEMOP_NONE, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1);
    check("nop_req", req_n, 0);
    check("nop_stall", stall_n, 0);
    run_access(3'b110, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1);
    check("illegal_req", req_n, 0);
    check("illegal_stall", stall_n, 0);

    // Timeout with no ack
    run_access(MEMOP_WORD, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0);
    check("to_req_cycles", req_n, 16);
    check("to_buserror", be_n, 1);
    check("to_loaddata", ld_done, 0);
    check("to_no_loadvalid", lv_n, 0);

    // Misaligned LW at 0x6; also proves the FSM returned to IDLE after timeout
    run_access(MEMOP_WORD, 1'b0, 1'b0, 32'h6, 32'h0, 32'hCAFE_F00D, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_pulse", mis_n, 1);
    check("mis_req", req_n, 0);
    check("mis_stall", stall_n, 0);
`else
    check("mis_none", mis_n, 0);
    check("mis_addr", cap_addr, 32'h4);
    check("mis_be", cap_be, 32'b1111);
    check("mis_data", ld_done, 32'hCAFE_F00D);
`endif

    // Reset during REQ aborts at once; an illegal op afterwards does nothing
    Valid = 1'b1; MemOp = MEMOP_WORD; MemWrite = 1'b1; Addr = 32'h20; StoreData = 32'h1;
    tick;
    Valid = 1'b0;
    check("rr_req_up", 32'(dm_req), 1);
    #2 reset = 1'b1;
    MemOp = 3'b011; Valid = 1'b1;
    #1;
    check("rr_req_drop", 32'(dm_req), 0);
    check("rr_outputs", {dm_addr[31:3], dm_we, Stall, LoadValid}, 0);
    check("rr_loaddata", LoadData, 0);
    @(negedge clk) reset = 1'b0;
    lv_n = 0; be_n = 0; mis_n = 0; req_n = 0; stall_n = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      req_n += int'(dm_req);
      stall_n += int'(Stall);
      sample_pulses();
    end
    check("rr_no_req", req_n, 0);
    check("rr_no_stall", stall_n, 0);
    check("rr_no_pulses", lv_n + be_n + mis_n, 0);
    Valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
